vga_scan_engine: RTL

- Parametrised successor to the fixed 640x480 VGA timing plus frame-address generation path.
- Generates VGA timing from the system clock through an internal pixel-tick divider, so no separate derived clock is needed.
- Maps the scan position to a downscaled frame-buffer address, with per-frame hardware scrolling and wrap-around.
- Delays sync and valid to line up with synchronous-RAM read latency, then drives gated RGB straight to the VGA pins.

---
 rtl/vga_pkg.sv | 53 +++++
 rtl/vga_timing.sv | 86 ++++++++
 rtl/vga_scan_engine.sv | 125 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA scan definitions: default timing, line/frame total derivation,
// scroll-mode encoding, sync pipeline payload and a modular-add helper.
package vga_pkg;

   localparam int unsigned CNT_W        = 10;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP_DEF     = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BP_DEF     = 48;
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP_DEF     = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 33;
   localparam int unsigned CLK_DIV_DEF  = 4;
   localparam int unsigned SCALE_DEF    = 1;
   localparam int unsigned IMG_W_DEF    = 320;
   localparam int unsigned IMG_H_DEF    = 240;
   localparam int unsigned ADDR_W_DEF   = 17;
   localparam int unsigned PIX_W_DEF    = 12;
   localparam int unsigned RD_LAT_DEF   = 1;

   localparam logic [1:0] SCROLL_NONE = 2'd0;
   localparam logic [1:0] SCROLL_H    = 2'd1;
   localparam logic [1:0] SCROLL_V    = 2'd2;
   localparam logic [1:0] SCROLL_HV   = 2'd3;

   // Sync/active flags carried through the RAM-latency alignment pipeline
   typedef struct packed {
      logic hsync;
      logic vsync;
      logic active;
   } sync_t;

   // Total ticks per line (or lines per frame)
   function automatic int unsigned line_total(input int unsigned active_len,
                                              input int unsigned fp_len,
                                              input int unsigned sync_len,
                                              input int unsigned bp_len);
      return active_len + fp_len + sync_len + bp_len;
   endfunction

   // (a + b) mod m, valid when a < m and b < m (single conditional subtract)
   function automatic logic [CNT_W-1:0] mod_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b,
                                                input logic [CNT_W-1:0] m);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= {1'b0, m}) sum = sum - {1'b0, m};
      return sum[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick divider, horizontal/vertical scan counters, raw sync/active
// decode and frame_start pulse.
// Ports: clk, rst (async active-low); h_cnt_o/v_cnt_o scan position;
// frame_start_o high for the clk of the tick at (0,0); *_raw_c undelayed
// sync/active; frame_end_c marks the tick that wraps (H_TOTAL-1,V_TOTAL-1).
module vga_timing
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FP     = H_FP_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BP     = H_BP_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FP     = V_FP_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BP     = V_BP_DEF,
   parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   output logic [CNT_W-1:0] h_cnt_o,
   output logic [CNT_W-1:0] v_cnt_o,
   output logic             frame_start_o,
   output logic             frame_end_c,
   output logic             hsync_raw_c,
   output logic             vsync_raw_c,
   output logic             active_raw_c
);

   localparam int unsigned H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int unsigned DIV_W   = $clog2(CLK_DIV);

   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
   logic             fs_q, fs_d;
   logic             tick_c, h_wrap_c, v_wrap_c;

   assign tick_c   = (div_q == DIV_W'(CLK_DIV - 1));
   assign h_wrap_c = (h_q == CNT_W'(H_TOTAL - 1));
   assign v_wrap_c = (v_q == CNT_W'(V_TOTAL - 1));

   // Next-state for divider and counters; frame_start is set one clk early
   // so the registered pulse coincides with the (0,0) tick itself.
   always_comb begin
      div_d = div_q + DIV_W'(1);
      h_d   = h_q;
      v_d   = v_q;
      if (tick_c) begin
         div_d = '0;
         if (h_wrap_c) begin
            h_d = '0;
            v_d = v_wrap_c ? '0 : v_q + CNT_W'(1);
         end else begin
            h_d = h_q + CNT_W'(1);
         end
      end
      fs_d = (div_q == DIV_W'(CLK_DIV - 2)) && (h_q == '0) && (v_q == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q <= '0;
         h_q   <= '0;
         v_q   <= '0;
         fs_q  <= 1'b0;
      end else begin
         div_q <= div_d;
         h_q   <= h_d;
         v_q   <= v_d;
         fs_q  <= fs_d;
      end
   end

   assign frame_end_c  = tick_c && h_wrap_c && v_wrap_c;
   assign hsync_raw_c  = ((h_q >= CNT_W'(H_ACTIVE + H_FP)) &&
                          (h_q <  CNT_W'(H_ACTIVE + H_FP + H_SYNC))) ? SYNC_POL : ~SYNC_POL;
   assign vsync_raw_c  = ((v_q >= CNT_W'(V_ACTIVE + V_FP)) &&
                          (v_q <  CNT_W'(V_ACTIVE + V_FP + V_SYNC))) ? SYNC_POL : ~SYNC_POL;
   assign active_raw_c = (h_q < CNT_W'(H_ACTIVE)) && (v_q < CNT_W'(V_ACTIVE));
   assign h_cnt_o       = h_q;
   assign v_cnt_o       = v_q;
   assign frame_start_o = fs_q;

endmodule

// File: rtl/vga_scan_engine.sv
// VGA scan engine: timing, per-frame scroll offsets, downscaled frame-buffer
// address, RAM-latency alignment of sync/valid and gated RGB output.
// Ports: clk, rst (async active-low); scroll_mode/scroll_step/freeze scroll
// control sampled at frame end; pixel_addr -> RAM, pixel_in <- RAM;
// rgb/hsync/vsync/valid to the VGA pins; h_cnt/v_cnt/frame_start undelayed.
module vga_scan_engine
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
   parameter int unsigned H_FP        = H_FP_DEF,
   parameter int unsigned H_SYNC      = H_SYNC_DEF,
   parameter int unsigned H_BP        = H_BP_DEF,
   parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
   parameter int unsigned V_FP        = V_FP_DEF,
   parameter int unsigned V_SYNC      = V_SYNC_DEF,
   parameter int unsigned V_BP        = V_BP_DEF,
   parameter int unsigned CLK_DIV     = CLK_DIV_DEF,
   parameter int unsigned SCALE_SHIFT = SCALE_DEF,
   parameter int unsigned IMG_W       = IMG_W_DEF,
   parameter int unsigned IMG_H       = IMG_H_DEF,
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned PIX_W       = PIX_W_DEF,
   parameter int unsigned RD_LAT      = RD_LAT_DEF,
   parameter bit          SYNC_POL    = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        scroll_mode,
   input  logic [7:0]        scroll_step,
   input  logic              freeze,
   output logic [ADDR_W-1:0] pixel_addr,
   input  logic [PIX_W-1:0]  pixel_in,
   output logic [PIX_W-1:0]  rgb,
   output logic              hsync,
   output logic              vsync,
   output logic              valid,
   output logic [CNT_W-1:0]  h_cnt,
   output logic [CNT_W-1:0]  v_cnt,
   output logic              frame_start
);

   localparam sync_t PIPE_RST = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, active: 1'b0};

   logic             frame_end_c, hsync_raw_c, vsync_raw_c, active_raw_c;
   logic [CNT_W-1:0] off_x_q, off_x_d, off_y_q, off_y_d;
   logic [CNT_W-1:0] x_img_c, y_img_c;
   logic [ADDR_W-1:0] addr_q, addr_d;
   sync_t            pipe_q [RD_LAT+1];
   logic [PIX_W-1:0] rgb_q;
   logic             hsync_q, vsync_q, valid_q;

   vga_timing #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
      .CLK_DIV  (CLK_DIV),  .SYNC_POL (SYNC_POL)
   ) u_timing (
      .clk           (clk),
      .rst           (rst),
      .h_cnt_o       (h_cnt),
      .v_cnt_o       (v_cnt),
      .frame_start_o (frame_start),
      .frame_end_c   (frame_end_c),
      .hsync_raw_c   (hsync_raw_c),
      .vsync_raw_c   (vsync_raw_c),
      .active_raw_c  (active_raw_c)
   );

   // Scroll offsets move only on the frame-wrap tick, so the image never tears
   always_comb begin
      off_x_d = off_x_q;
      off_y_d = off_y_q;
      if (frame_end_c && !freeze) begin
         case (scroll_mode)
            SCROLL_NONE: begin end
            SCROLL_H:    off_x_d = mod_add(off_x_q, CNT_W'(scroll_step), CNT_W'(IMG_W));
            SCROLL_V:    off_y_d = mod_add(off_y_q, CNT_W'(scroll_step), CNT_W'(IMG_H));
            SCROLL_HV: begin
               off_x_d = mod_add(off_x_q, CNT_W'(scroll_step), CNT_W'(IMG_W));
               off_y_d = mod_add(off_y_q, CNT_W'(scroll_step), CNT_W'(IMG_H));
            end
            default: begin end
         endcase
      end
   end

   // Downscaled, scrolled image coordinate -> linear frame-buffer address
   always_comb begin
      x_img_c = mod_add(h_cnt >> SCALE_SHIFT, off_x_q, CNT_W'(IMG_W));
      y_img_c = mod_add(v_cnt >> SCALE_SHIFT, off_y_q, CNT_W'(IMG_H));
      addr_d  = active_raw_c ? (ADDR_W'(y_img_c) * ADDR_W'(IMG_W) + ADDR_W'(x_img_c))
                             : '0;
   end

   // Address register, sync pipeline (stage RD_LAT lines up with pixel_in)
   // and output register holding the gated pixel.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         off_x_q <= '0;
         off_y_q <= '0;
         addr_q  <= '0;
         for (int i = 0; i <= RD_LAT; i++) pipe_q[i] <= PIPE_RST;
         rgb_q   <= '0;
         hsync_q <= ~SYNC_POL;
         vsync_q <= ~SYNC_POL;
         valid_q <= 1'b0;
      end else begin
         off_x_q   <= off_x_d;
         off_y_q   <= off_y_d;
         addr_q    <= addr_d;
         pipe_q[0] <= '{hsync: hsync_raw_c, vsync: vsync_raw_c, active: active_raw_c};
         for (int i = 1; i <= RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
         rgb_q     <= pipe_q[RD_LAT].active ? pixel_in : '0;
         hsync_q   <= pipe_q[RD_LAT].hsync;
         vsync_q   <= pipe_q[RD_LAT].vsync;
         valid_q   <= pipe_q[RD_LAT].active;
      end
   end

   assign pixel_addr = addr_q;
   assign rgb        = rgb_q;
   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign valid      = valid_q;

endmodule
